pc_branch_unit: RTL and testbench

Parametrised program-counter unit, the successor to the plain load/increment PC. It holds the CPU program counter as a low (page) field and a high field. It supports load, increment, and 6502-style signed relative branches whose page-crossing high-byte fix-up takes a second, separately sequenced cycle. It sits between the control unit (commands) and the address bus/internal data bus (PCL/PCH outputs).

---
 rtl/pc_branch_unit.sv | 72 +++++++
 tb/tb_pc_branch_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pc_branch_unit.sv
// Program counter with load, increment and 6502-style relative branch.
// A branch that crosses a page takes a second cycle to adjust the high field.
module pc_branch_unit #(
  parameter int PAGE_W = 8,
  parameter int HI_W   = 8,
  parameter logic [PAGE_W+HI_W-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PAGE_W-1:0] PCL_in,
  input  logic [HI_W-1:0]   PCH_in,
  input  logic              load,
  input  logic              inc_enable,
  input  logic              branch,
  input  logic [PAGE_W-1:0] offset,
  output logic [PAGE_W-1:0] PCL_out,
  output logic [HI_W-1:0]   PCH_out,
  output logic              busy,
  output logic              page_cross
);
  localparam int PC_W = PAGE_W + HI_W;

  typedef enum logic {IDLE, FIXUP} state_t;

  state_t            r_state;
  logic [PAGE_W-1:0] r_pcl;
  logic [HI_W-1:0]   r_pch;
  logic              r_dir_dn;
  logic              r_page_cross;

  logic [PAGE_W:0]   w_sum;
  logic              w_cross;
  logic [PC_W-1:0]   w_inc;

  assign w_sum = {1'b0, r_pcl} + {1'b0, offset};
  // Forward offset crosses on carry out; backward offset crosses on no carry.
  assign w_cross = offset[PAGE_W-1] ? ~w_sum[PAGE_W] : w_sum[PAGE_W];
  assign w_inc   = {r_pch, r_pcl} + PC_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {r_pch, r_pcl} <= RESET_VALUE;
      r_state        <= IDLE;
      r_dir_dn       <= 1'b0;
      r_page_cross   <= 1'b0;
    end else begin
      r_page_cross <= 1'b0;
      if (load) begin
        r_pcl   <= PCL_in;
        r_pch   <= PCH_in;
        r_state <= IDLE;
      end else if (r_state == FIXUP) begin
        r_pch   <= r_dir_dn ? r_pch - HI_W'(1) : r_pch + HI_W'(1);
        r_state <= IDLE;
      end else if (branch) begin
        r_pcl    <= w_sum[PAGE_W-1:0];
        r_dir_dn <= offset[PAGE_W-1];
        if (w_cross) begin
          r_state      <= FIXUP;
          r_page_cross <= 1'b1;
        end
      end else if (inc_enable) begin
        {r_pch, r_pcl} <= w_inc;
      end
    end
  end

  assign PCL_out    = r_pcl;
  assign PCH_out    = r_pch;
  assign busy       = (r_state == FIXUP);
  assign page_cross = r_page_cross;
endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: expectations queued at drive time, popped after each edge.
module tb_pc_branch_unit;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] PCL_in = '0;
  logic [7:0] PCH_in = '0;
  logic       load = 1'b0;
  logic       inc_enable = 1'b0;
  logic       branch = 1'b0;
  logic [7:0] offset = '0;
  logic [7:0] PCL_out;
  logic [7:0] PCH_out;
  logic       busy;
  logic       page_cross;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [15:0] pc;
    logic        busy;
    logic        pcx;
  } exp_t;
  exp_t sb[$];

  pc_branch_unit #(.PAGE_W(8), .HI_W(8), .RESET_VALUE(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .PCL_in(PCL_in), .PCH_in(PCH_in),
    .load(load), .inc_enable(inc_enable), .branch(branch), .offset(offset),
    .PCL_out(PCL_out), .PCH_out(PCH_out), .busy(busy), .page_cross(page_cross)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [15:0] pc, input logic b, input logic p);
    exp_t e;
    e.tag = tag; e.pc = pc; e.busy = b; e.pcx = p;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic [15:0] obs;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_empty observed 0 entries expected >=1");
      return;
    end
    e = sb.pop_front();
    obs = {PCH_out, PCL_out};
    tests++;
    assert (obs === e.pc) else begin
      fails++;
      $error("FAIL %s pc observed %h expected %h", e.tag, obs, e.pc);
    end
    tests++;
    assert (busy === e.busy) else begin
      fails++;
      $error("FAIL %s busy observed %b expected %b", e.tag, busy, e.busy);
    end
    tests++;
    assert (page_cross === e.pcx) else begin
      fails++;
      $error("FAIL %s page_cross observed %b expected %b", e.tag, page_cross, e.pcx);
    end
  endtask

  // Drive one command for one clock edge, then compare 1ns after the edge.
  task automatic cyc(input logic ld, input logic br, input logic inc,
                     input logic [15:0] din, input logic [7:0] off,
                     input string tag, input logic [15:0] epc,
                     input logic eb, input logic ep);
    load = ld; branch = br; inc_enable = inc;
    {PCH_in, PCL_in} = din; offset = off;
    push(tag, epc, eb, ep);
    @(posedge clk);
    #1;
    load = 1'b0; branch = 1'b0; inc_enable = 1'b0;
    pop_check();
  endtask

  task automatic async_reset(input string tag);
    #2 reset_n = 1'b0;
    push(tag, 16'h0000, 1'b0, 1'b0);
    #1 pop_check();
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #1;
    push("reset_init", 16'h0000, 1'b0, 1'b0);
    pop_check();
    @(posedge clk); #1 reset_n = 1'b1;

    cyc(1, 0, 0, 16'h1234, 8'h00, "load_1234", 16'h1234, 0, 0);
    async_reset("reset_mid_cycle");

    cyc(1, 0, 0, 16'h12FF, 8'h00, "load_12ff", 16'h12FF, 0, 0);
    cyc(0, 0, 1, 16'h0000, 8'h00, "inc_carry", 16'h1300, 0, 0);
    cyc(1, 0, 0, 16'hFFFF, 8'h00, "load_ffff", 16'hFFFF, 0, 0);
    cyc(0, 0, 1, 16'h0000, 8'h00, "inc_wrap",  16'h0000, 0, 0);

    cyc(1, 0, 0, 16'h1280, 8'h00, "load_1280",  16'h1280, 0, 0);
    cyc(0, 1, 0, 16'h0000, 8'h10, "br_fwd_nc",  16'h1290, 0, 0);
    cyc(0, 1, 0, 16'h0000, 8'hF0, "br_back_nc", 16'h1280, 0, 0);
    cyc(0, 0, 0, 16'h0000, 8'h00, "br_nc_hold", 16'h1280, 0, 0);

    cyc(1, 0, 0, 16'h12F0, 8'h00, "load_12f0",  16'h12F0, 0, 0);
    cyc(0, 1, 0, 16'h0000, 8'h20, "fwd_x_e1",   16'h1210, 1, 1);
    cyc(0, 0, 0, 16'h0000, 8'h00, "fwd_x_e2",   16'h1310, 0, 0);

    cyc(1, 0, 0, 16'h1205, 8'h00, "load_1205",  16'h1205, 0, 0);
    cyc(0, 1, 0, 16'h0000, 8'hF0, "back_x_e1",  16'h12F5, 1, 1);
    cyc(0, 0, 0, 16'h0000, 8'h00, "back_x_e2",  16'h11F5, 0, 0);

    // Negative offset with carry out stays in the page.
    cyc(1, 0, 0, 16'h00F0, 8'h00, "load_00f0",  16'h00F0, 0, 0);
    cyc(0, 1, 0, 16'h0000, 8'hE0, "back_in_pg", 16'h00D0, 0, 0);
    cyc(1, 0, 0, 16'h0005, 8'h00, "load_0005",  16'h0005, 0, 0);
    cyc(0, 1, 0, 16'h0000, 8'hF0, "hwrap_dn_e1", 16'h00F5, 1, 1);
    cyc(0, 0, 0, 16'h0000, 8'h00, "hwrap_dn_e2", 16'hFFF5, 0, 0);
    cyc(1, 0, 0, 16'hFFF0, 8'h00, "load_fff0",  16'hFFF0, 0, 0);
    cyc(0, 1, 0, 16'h0000, 8'h20, "hwrap_up_e1", 16'hFF10, 1, 1);
    cyc(0, 0, 0, 16'h0000, 8'h00, "hwrap_up_e2", 16'h0010, 0, 0);

    cyc(1, 0, 0, 16'h12F0, 8'h00, "load_12f0b", 16'h12F0, 0, 0);
    cyc(0, 1, 0, 16'h0000, 8'h20, "abort_e1",   16'h1210, 1, 1);
    cyc(1, 0, 0, 16'hABCD, 8'h00, "abort_load", 16'hABCD, 0, 0);
    cyc(0, 0, 0, 16'h0000, 8'h00, "abort_hold", 16'hABCD, 0, 0);

    cyc(1, 0, 0, 16'h12F0, 8'h00, "load_12f0c", 16'h12F0, 0, 0);
    cyc(0, 1, 0, 16'h0000, 8'h20, "inc_fx_e1",  16'h1210, 1, 1);
    cyc(0, 0, 1, 16'h0000, 8'h00, "inc_fx_ign", 16'h1310, 0, 0);

    cyc(1, 0, 0, 16'h12F0, 8'h00, "load_12f0d", 16'h12F0, 0, 0);
    cyc(0, 1, 0, 16'h0000, 8'h20, "br_fx_e1",   16'h1210, 1, 1);
    cyc(0, 1, 0, 16'h0000, 8'h05, "br_fx_ign",  16'h1310, 0, 0);

    cyc(1, 0, 0, 16'h12F0, 8'h00, "load_12f0e", 16'h12F0, 0, 0);
    cyc(0, 1, 0, 16'h0000, 8'h20, "rst_fx_e1",  16'h1210, 1, 1);
    async_reset("rst_in_fixup");
    cyc(0, 0, 0, 16'h0000, 8'h00, "rst_fx_idle", 16'h0000, 0, 0);

    cyc(1, 1, 1, 16'h5678, 8'h20, "all_cmds",   16'h5678, 0, 0);
    cyc(0, 0, 0, 16'h0000, 8'h00, "all_hold",   16'h5678, 0, 0);

    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_leftover observed %0d entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
